// File: rtl/eth_stream_pkg.sv
// Shared definitions for the Ethernet receive stream path.
package eth_stream_pkg;

  localparam int DEFAULT_COUNT_WIDTH = 32;

  typedef enum logic {ST_IDLE, ST_PASS} arb_state_e;

  // tdest needs at least one bit even for a single channel
  function automatic int dest_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// 2-entry AXI-Stream register slice; input ready depends only on occupancy.
module axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] i_payload,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_payload,
  output logic             o_valid,
  input  logic             i_ready
);

  logic [1:0][WIDTH-1:0] r_mem;
  logic                  r_wr, r_rd;
  logic [1:0]            r_cnt;
  logic                  w_push, w_pop;

  assign o_ready   = (r_cnt != 2'd2);
  assign o_valid   = (r_cnt != 2'd0);
  assign o_payload = r_mem[r_rd];
  assign w_push    = i_valid && o_ready;
  assign w_pop     = o_valid && i_ready;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_mem <= '0;
      r_wr  <= 1'b0;
      r_rd  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_payload;
        r_wr        <= ~r_wr;
      end
      if (w_pop) r_rd <= ~r_rd;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/eth_rx_arbiter.sv
// Frame-granular round-robin merge of CHANNELS MAC receive streams, with
// per-channel frame/error counters.
module eth_rx_arbiter
  import eth_stream_pkg::*;
#(
  parameter  int CHANNELS    = 2,
  parameter  int DATA_WIDTH  = 64,
  parameter  int COUNT_WIDTH = DEFAULT_COUNT_WIDTH,
  localparam int KEEP_WIDTH  = DATA_WIDTH / 8,
  localparam int DEST_WIDTH  = dest_width(CHANNELS)
) (
  input  logic                            clock,
  input  logic                            resetn,
  input  logic [CHANNELS-1:0]             chan_enable,
  input  logic [CHANNELS*DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [CHANNELS*KEEP_WIDTH-1:0]  s_axis_tkeep,
  input  logic [CHANNELS-1:0]             s_axis_tlast,
  input  logic [CHANNELS-1:0]             s_axis_tuser,
  input  logic [CHANNELS-1:0]             s_axis_tvalid,
  output logic [CHANNELS-1:0]             s_axis_tready,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]           m_axis_tkeep,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tuser,
  output logic                            m_axis_tvalid,
  output logic [DEST_WIDTH-1:0]           m_axis_tdest,
  input  logic                            m_axis_tready,
  output logic [CHANNELS*COUNT_WIDTH-1:0] frame_count,
  output logic [CHANNELS*COUNT_WIDTH-1:0] error_count
);

  localparam int PAY_W = DATA_WIDTH + KEEP_WIDTH + 2 + DEST_WIDTH;

  arb_state_e                r_state, w_state_nxt;
  logic [DEST_WIDTH-1:0]     r_grant, r_last_grant, w_pick;
  logic                      w_pick_vld;
  logic [CHANNELS-1:0]       w_req;
  logic                      w_gvalid, w_glast, w_guser, w_acc, w_skid_rdy;
  logic [DATA_WIDTH-1:0]     w_gdata;
  logic [KEEP_WIDTH-1:0]     w_gkeep;
  logic [PAY_W-1:0]          w_s_pay, w_m_pay;
  logic [CHANNELS-1:0][COUNT_WIDTH-1:0] w_frm_cnt, w_err_cnt;

  assign w_req = s_axis_tvalid & chan_enable;

  // Walk from the farthest candidate to the nearest so the nearest after
  // last_grant is the final assignment.
  always_comb begin
    w_pick     = '0;
    w_pick_vld = 1'b0;
    for (int k = CHANNELS; k >= 1; k--) begin
      for (int j = 0; j < CHANNELS; j++) begin
        if (j == (int'(r_last_grant) + k) % CHANNELS && w_req[j]) begin
          w_pick     = DEST_WIDTH'(j);
          w_pick_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_gvalid = 1'b0;
    w_gdata  = '0;
    w_gkeep  = '0;
    w_glast  = 1'b0;
    w_guser  = 1'b0;
    for (int j = 0; j < CHANNELS; j++) begin
      if (r_grant == DEST_WIDTH'(j)) begin
        w_gvalid = s_axis_tvalid[j];
        w_gdata  = s_axis_tdata[j*DATA_WIDTH +: DATA_WIDTH];
        w_gkeep  = s_axis_tkeep[j*KEEP_WIDTH +: KEEP_WIDTH];
        w_glast  = s_axis_tlast[j];
        w_guser  = s_axis_tuser[j];
      end
    end
  end

  always_comb begin
    s_axis_tready = '0;
    if (r_state == ST_PASS) begin
      for (int j = 0; j < CHANNELS; j++)
        if (r_grant == DEST_WIDTH'(j)) s_axis_tready[j] = w_skid_rdy;
    end
  end

  assign w_acc = (r_state == ST_PASS) && w_gvalid && w_skid_rdy;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_pick_vld) w_state_nxt = ST_PASS;
      ST_PASS: if (w_acc && w_glast) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= DEST_WIDTH'(CHANNELS - 1);
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_pick_vld) r_grant <= w_pick;
      if (w_acc && w_glast) r_last_grant <= r_grant;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_cnt
    logic [COUNT_WIDTH-1:0] r_frm, r_err;
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        r_frm <= '0;
        r_err <= '0;
      end else if (w_acc && w_glast && r_grant == DEST_WIDTH'(i)) begin
        r_frm <= r_frm + COUNT_WIDTH'(1);
        if (w_guser) r_err <= r_err + COUNT_WIDTH'(1);
      end
    end
    assign w_frm_cnt[i] = r_frm;
    assign w_err_cnt[i] = r_err;
  end

  assign frame_count = w_frm_cnt;
  assign error_count = w_err_cnt;

  assign w_s_pay = {w_gdata, w_gkeep, w_glast, w_guser, r_grant};

  axis_skid_buffer #(.WIDTH(PAY_W)) u_skid (
    .clock     (clock),
    .resetn    (resetn),
    .i_payload (w_s_pay),
    .i_valid   (w_acc),
    .o_ready   (w_skid_rdy),
    .o_payload (w_m_pay),
    .o_valid   (m_axis_tvalid),
    .i_ready   (m_axis_tready)
  );

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, m_axis_tdest} = w_m_pay;

endmodule

// File: tb/tb_eth_rx_arbiter.sv
// Scoreboard bench for eth_rx_arbiter: per-channel expected beat queues,
// frame-order log and counter model.
module tb_eth_rx_arbiter;

  localparam int CH = 2;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int CW = 4;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic          user;
    int            cyc;
  } beat_t;

  logic               clock, resetn;
  logic [CH-1:0]      chan_enable;
  logic [CH*DW-1:0]   s_axis_tdata;
  logic [CH*KW-1:0]   s_axis_tkeep;
  logic [CH-1:0]      s_axis_tlast, s_axis_tuser, s_axis_tvalid, s_axis_tready;
  logic [DW-1:0]      m_axis_tdata;
  logic [KW-1:0]      m_axis_tkeep;
  logic               m_axis_tlast, m_axis_tuser, m_axis_tvalid, m_axis_tready;
  logic [0:0]         m_axis_tdest;
  logic [CH*CW-1:0]   frame_count, error_count;

  eth_rx_arbiter #(.CHANNELS(CH), .DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .resetn(resetn), .chan_enable(chan_enable),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdest(m_axis_tdest),
    .m_axis_tready(m_axis_tready),
    .frame_count(frame_count), .error_count(error_count)
  );

  // negedge at 5, posedge at 10: tb drives at negedge, samples at negedge+1
  initial begin
    clock = 1'b1;
    forever #5 clock = ~clock;
  end

  beat_t gen_q[CH][$];
  beat_t exp_q[CH][$];
  int    order_q[$];
  int    exp_frm[CH], exp_err[CH];
  int    n_cmp = 0, n_bad = 0, cyc = 0;
  int    vprob = 100, mprob = 100;
  bit    lat_chk = 0;
  logic [CH-1:0] hs = '0;
  bit    held = 0, in_frame = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic add_frame(input int ch, input int len, input bit err);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = {$urandom, $urandom};
      b.last = (i == len - 1);
      b.keep = b.last ? KW'($urandom_range(1, 255)) : '1;
      b.user = b.last ? err : 1'($urandom_range(0, 1));
      b.cyc  = 0;
      gen_q[ch].push_back(b);
    end
  endtask

  // One cycle: retire last cycle's handshakes, drive new inputs, then record
  // the handshakes that will occur at the coming posedge.
  task automatic step();
    beat_t b;
    @(negedge clock);
    cyc++;
    for (int ch = 0; ch < CH; ch++) begin
      if (hs[ch]) void'(gen_q[ch].pop_front());
      if (!(s_axis_tvalid[ch] && !hs[ch])) begin
        if (gen_q[ch].size() > 0 && $urandom_range(99) < vprob) begin
          b = gen_q[ch][0];
          s_axis_tdata[ch*DW +: DW] = b.data;
          s_axis_tkeep[ch*KW +: KW] = b.keep;
          s_axis_tlast[ch] = b.last;
          s_axis_tuser[ch] = b.user;
          s_axis_tvalid[ch] = 1'b1;
        end else begin
          s_axis_tvalid[ch] = 1'b0;
        end
      end
    end
    m_axis_tready = ($urandom_range(99) < mprob);
    #1;
    for (int ch = 0; ch < CH; ch++) begin
      hs[ch] = s_axis_tvalid[ch] && s_axis_tready[ch];
      if (hs[ch]) begin
        b = gen_q[ch][0];
        b.cyc = cyc;
        exp_q[ch].push_back(b);
        if (b.last) begin
          exp_frm[ch] = (exp_frm[ch] + 1) % (1 << CW);
          if (b.user) exp_err[ch] = (exp_err[ch] + 1) % (1 << CW);
        end
      end
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((gen_q[0].size() > 0 || gen_q[1].size() > 0 || exp_q[0].size() > 0 ||
            exp_q[1].size() > 0 || m_axis_tvalid) && n < budget) begin
      step();
      n++;
    end
    n_cmp++;
    if (n >= budget) begin
      n_bad++;
      $display("FAIL drain: still busy after %0d cycles, required idle", n);
    end
  endtask

  task automatic chk_cnt();
    for (int ch = 0; ch < CH; ch++) begin
      check($sformatf("frame_count%0d", ch), frame_count[ch*CW +: CW], exp_frm[ch]);
      check($sformatf("error_count%0d", ch), error_count[ch*CW +: CW], exp_err[ch]);
    end
  endtask

  task automatic pulse_reset();
    #1 resetn = 1'b0;
    #1;
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_s_tready", s_axis_tready, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_error_count", error_count, 0);
    for (int ch = 0; ch < CH; ch++) begin
      gen_q[ch].delete();
      exp_q[ch].delete();
      exp_frm[ch] = 0;
      exp_err[ch] = 0;
    end
    order_q.delete();
    hs = '0;
    s_axis_tvalid = '0;
    held = 0;
    in_frame = 0;
    @(negedge clock);
    resetn = 1'b1;
  endtask

  // Output monitor
  initial begin
    beat_t e;
    logic [DW+KW+1:0] pay, held_pay;
    logic [0:0] held_dest;
    int d, cur;
    cur = 0;
    forever begin
      @(negedge clock);
      #1;
      if (resetn) begin
        pay = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
        if (held)
          check("m_hold_stable", {m_axis_tvalid, pay, m_axis_tdest}, {1'b1, held_pay, held_dest});
        held      = m_axis_tvalid && !m_axis_tready;
        held_pay  = pay;
        held_dest = m_axis_tdest;
        if (m_axis_tvalid && m_axis_tready) begin
          d = int'(m_axis_tdest);
          if (exp_q[d].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_beat: got tdest %0d data %h, expected no beat", d, m_axis_tdata);
          end else begin
            e = exp_q[d].pop_front();
            check("beat", pay, {e.data, e.keep, e.last, e.user});
            if (lat_chk) check("latency", cyc, e.cyc + 1);
          end
          if (in_frame) check("frame_tdest", d, cur);
          in_frame = !m_axis_tlast;
          cur = d;
          if (m_axis_tlast) order_q.push_back(d);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    resetn = 1'b0;
    chan_enable = '1;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = '0;
    s_axis_tuser = '0; s_axis_tvalid = '0; m_axis_tready = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    check("rst_s_tready", s_axis_tready, 0);
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_m_payload", {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, m_axis_tdest}, 0);
    check("rst_counts", {frame_count, error_count}, 0);
    @(negedge clock);
    resetn = 1'b1;

    // single 3-beat frame on ch0, latency n+1
    lat_chk = 1;
    add_frame(0, 3, 0);
    drain(100);
    chk_cnt();
    check("ch0_one_frame", frame_count[CW-1:0], 1);

    // both channels continuously from reset: frames alternate 0,1,0,1
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      add_frame(0, 2, 0);
      add_frame(1, 2, 0);
    end
    drain(200);
    lat_chk = 0;
    check("rr_count", order_q.size(), 12);
    foreach (order_q[i]) check("rr_order", order_q[i], i % 2);
    chk_cnt();

    // output stall mid-frame
    add_frame(0, 8, 1);
    repeat (3) step();
    mprob = 0;
    repeat (5) step();
    check("stall_s_tready", s_axis_tready[0], 0);
    check("stall_m_tvalid", m_axis_tvalid, 1);
    mprob = 100;
    drain(100);
    chk_cnt();

    // ch0 disabled: only ch1 frames pass
    order_q.delete();
    chan_enable = 2'b10;
    add_frame(0, 2, 0);
    for (int i = 0; i < 3; i++) add_frame(1, 2, i == 1);
    repeat (30) step();
    check("dis_ch0_pending", gen_q[0].size(), 2);
    check("dis_frames", order_q.size(), 3);
    foreach (order_q[i]) check("dis_order", order_q[i], 1);
    // clearing the enable of the granted channel lets its frame finish
    add_frame(1, 6, 1);
    n = 0;
    while (!s_axis_tready[1] && n < 50) begin
      step();
      n++;
    end
    check("grant_ch1_seen", s_axis_tready[1], 1);
    chan_enable = 2'b00;
    repeat (20) step();
    check("midclr_done", gen_q[1].size(), 0);
    check("midclr_frames", order_q.size(), 4);
    check("midclr_ch0_blocked", gen_q[0].size(), 2);
    chan_enable = 2'b11;
    drain(100);
    chk_cnt();

    // 17 ch1 frames, one errored: 4-bit frame counter wraps to 1
    pulse_reset();
    for (int i = 0; i < 17; i++) add_frame(1, $urandom_range(1, 3), i == 6);
    drain(300);
    chk_cnt();
    check("wrap_frame1", frame_count[2*CW-1:CW], 1);
    check("wrap_error1", error_count[2*CW-1:CW], 1);

    // randomized traffic, backpressure and enable changes
    vprob = 70;
    mprob = 60;
    for (int i = 0; i < 40; i++) add_frame($urandom_range(0, 1), $urandom_range(1, 4), $urandom_range(0, 3) == 0);
    for (int s = 0; s < 400; s++) begin
      if (s % 20 == 0) chan_enable = 2'($urandom_range(0, 3));
      step();
    end
    chan_enable = 2'b11;
    drain(3000);
    chk_cnt();
    vprob = 100;
    mprob = 100;

    // reset mid-frame, then ch0 wins first
    add_frame(0, 10, 0);
    add_frame(1, 10, 0);
    repeat (6) step();
    pulse_reset();
    add_frame(1, 2, 0);
    add_frame(0, 2, 0);
    drain(100);
    check("post_rst_frames", order_q.size(), 2);
    if (order_q.size() > 0) check("post_rst_first", order_q[0], 0);
    chk_cnt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
